// File: rtl/mu0_pkg.sv
// mu0_pkg: shared encodings for the MU0 control unit
package mu0_pkg;
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_HALT  = 2'd2,
      S_FAULT = 2'd3
   } state_e;
   localparam logic [3:0] OP_LDA = 4'd0;
   localparam logic [3:0] OP_STA = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_JMP = 4'd4;
   localparam logic [3:0] OP_JGE = 4'd5;
   localparam logic [3:0] OP_JNE = 4'd6;
   localparam logic [3:0] OP_STP = 4'd7;
   localparam logic [1:0] ALU_PASS_Y = 2'b00;
   localparam logic [1:0] ALU_ADD    = 2'b01;
   localparam logic [1:0] ALU_INC    = 2'b10;
   localparam logic [1:0] ALU_SUB    = 2'b11;
   localparam logic X_ACC   = 1'b0;
   localparam logic X_PC    = 1'b1;
   localparam logic Y_MEM   = 1'b0;
   localparam logic Y_IR    = 1'b1;
   localparam logic ADDR_PC = 1'b0;
   localparam logic ADDR_IR = 1'b1;
   // memory-class opcodes occupy 0..3
   function automatic logic is_mem_op(input logic [3:0] op);
      return op[3:2] == 2'b00;
   endfunction
endpackage

// File: rtl/mu0_wait_timer.sv
// mu0_wait_timer: counts consecutive memory wait cycles and flags the last tolerated one
module mu0_wait_timer #(
   parameter int WAIT_LIMIT = 15,
   parameter int CNT_W      = 8
) (
   input  logic Clk,
   input  logic Reset,
   input  logic clr_i,
   input  logic inc_i,
   output logic timeout_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // clear wins over increment
   always_comb cnt_d = clr_i ? '0 : inc_i ? cnt_q + 1'b1 : cnt_q;
   // counter register, cleared asynchronously
   always_ff @(posedge Clk or negedge Reset)
      if (!Reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   assign timeout_o = cnt_q == CNT_W'(WAIT_LIMIT - 1);
endmodule

// File: rtl/mu0_control.sv
// mu0_control: fetch/execute sequencer for the MU0 datapath with wait-state timeout
module mu0_control
   import mu0_pkg::*;
#(
   parameter int WAIT_LIMIT = 15,
   parameter int CNT_W      = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [3:0] Opcode,
   input  logic       N_flag,
   input  logic       Z_flag,
   input  logic       Mem_Ready,
   output logic       IR_En,
   output logic       PC_En,
   output logic       Acc_En,
   output logic       X_sel,
   output logic       Y_sel,
   output logic       Addr_sel,
   output logic [1:0] ALU_fs,
   output logic       Mem_Rd,
   output logic       Mem_Wr,
   output logic       Halted,
   output logic       Fault
);
   state_e state_q, state_d;
   logic   mem_op, waiting, timeout;
   assign mem_op  = is_mem_op(Opcode);
   assign waiting = (state_q == S_FETCH || (state_q == S_EXEC && mem_op)) && !Mem_Ready;
   mu0_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) u_timer (
      .Clk       (Clk),
      .Reset     (Reset),
      .clr_i     (!waiting),
      .inc_i     (waiting),
      .timeout_o (timeout)
   );
   // state register, forced to FETCH asynchronously
   always_ff @(posedge Clk or negedge Reset)
      if (!Reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   // next state: memory accesses stall on Mem_Ready and fault on timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: state_d = Mem_Ready ? S_EXEC : timeout ? S_FAULT : S_FETCH;
         S_EXEC:  state_d = !mem_op ? (Opcode == OP_STP ? S_HALT : S_FETCH) :
                            Mem_Ready ? S_FETCH : timeout ? S_FAULT : S_EXEC;
         default: state_d = state_q;
      endcase
   end
   // decode outputs; everything is held low while Reset is asserted
   always_comb begin
      IR_En    = 1'b0;
      PC_En    = 1'b0;
      Acc_En   = 1'b0;
      X_sel    = X_ACC;
      Y_sel    = Y_MEM;
      Addr_sel = ADDR_PC;
      ALU_fs   = ALU_PASS_Y;
      Mem_Rd   = 1'b0;
      Mem_Wr   = 1'b0;
      Halted   = 1'b0;
      Fault    = 1'b0;
      if (Reset) begin
         case (state_q)
            S_FETCH: begin
               Mem_Rd = 1'b1;
               X_sel  = X_PC;
               ALU_fs = ALU_INC;
               IR_En  = Mem_Ready;
               PC_En  = Mem_Ready;
            end
            S_EXEC: begin
               if (mem_op) begin
                  Addr_sel = ADDR_IR;
                  Mem_Rd   = Opcode != OP_STA;
                  Mem_Wr   = Opcode == OP_STA;
                  Acc_En   = Mem_Ready && Opcode != OP_STA;
                  ALU_fs   = Opcode == OP_ADD ? ALU_ADD : Opcode == OP_SUB ? ALU_SUB : ALU_PASS_Y;
               end else if (Opcode == OP_JMP || Opcode == OP_JGE || Opcode == OP_JNE) begin
                  Y_sel = Y_IR;
                  PC_En = Opcode == OP_JMP ? 1'b1 : Opcode == OP_JGE ? !N_flag : !Z_flag;
               end
            end
            S_HALT:  Halted = 1'b1;
            default: Fault  = 1'b1;
         endcase
      end
   end
endmodule

// File: tb/tb_mu0_control.sv
// tb_mu0_control: scoreboard bench for the MU0 sequencer
module tb_mu0_control;
  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] Opcode = 4'd0;
  logic       N_flag = 1'b0, Z_flag = 1'b0, Mem_Ready = 1'b1;
  logic       IR_En, PC_En, Acc_En, X_sel, Y_sel, Addr_sel, Mem_Rd, Mem_Wr, Halted, Fault;
  logic [1:0] ALU_fs;
  logic [11:0] outs;
  int n_chk = 0, n_fail = 0;
  typedef struct { string nm; logic [11:0] v; } exp_t;
  exp_t exp_q[$];
  mu0_control #(.WAIT_LIMIT(15), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .N_flag(N_flag), .Z_flag(Z_flag),
    .Mem_Ready(Mem_Ready), .IR_En(IR_En), .PC_En(PC_En), .Acc_En(Acc_En),
    .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel), .ALU_fs(ALU_fs),
    .Mem_Rd(Mem_Rd), .Mem_Wr(Mem_Wr), .Halted(Halted), .Fault(Fault)
  );
  always #5 Clk = ~Clk;
  assign outs = {IR_En, PC_En, Acc_En, X_sel, Y_sel, Addr_sel, ALU_fs, Mem_Rd, Mem_Wr, Halted, Fault};
  localparam logic [11:0] ZERO   = 12'h000;
  localparam logic [11:0] F_WAIT = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [11:0] F_GO   = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [11:0] LDA_X  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [11:0] LDA_W  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [11:0] ADD_X  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [11:0] SUB_X  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [11:0] STA_X  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [11:0] JMP_T  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [11:0] JMP_N  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [11:0] HLT    = 12'b0000_0000_0010;
  localparam logic [11:0] FLT    = 12'b0000_0000_0001;
  always begin : mon
    exp_t e;
    @(negedge Clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (outs !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b (IR PC ACC X Y A FS FS RD WR H F)", e.nm, outs, e.v);
      end
    end
  end
  task automatic chk(input string nm, input logic [11:0] e);
    n_chk++;
    if (outs !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (direct)", nm, outs, e);
    end
  endtask
  task automatic cyc(input logic rdy, input logic [3:0] op, input logic n, input logic z,
                     input string nm, input logic [11:0] e);
    Mem_Ready = rdy; Opcode = op; N_flag = n; Z_flag = z;
    exp_q.push_back('{nm, e});
    @(posedge Clk); #1;
  endtask
  initial begin
    @(posedge Clk); #1;
    chk("reset_state", ZERO);
    for (int i = 0; i < 3; i++) cyc(1, 4'd0, 0, 0, "reset_hold", ZERO);
    Reset = 1'b1;
    cyc(1, 4'd0, 0, 0, "fetch_lda", F_GO);  cyc(1, 4'd0, 0, 0, "exec_lda", LDA_X);
    cyc(1, 4'd2, 0, 0, "fetch_add", F_GO);  cyc(1, 4'd2, 0, 0, "exec_add", ADD_X);
    cyc(1, 4'd1, 0, 0, "fetch_sta", F_GO);  cyc(1, 4'd1, 0, 0, "exec_sta", STA_X);
    cyc(1, 4'd3, 0, 0, "fetch_sub", F_GO);  cyc(1, 4'd3, 0, 0, "exec_sub", SUB_X);
    cyc(1, 4'd5, 1, 0, "fetch_jge", F_GO);  cyc(1, 4'd5, 1, 0, "jge_n1", JMP_N);
    cyc(1, 4'd5, 0, 0, "fetch_jge", F_GO);  cyc(1, 4'd5, 0, 0, "jge_n0", JMP_T);
    cyc(1, 4'd6, 0, 1, "fetch_jne", F_GO);  cyc(1, 4'd6, 0, 1, "jne_z1", JMP_N);
    cyc(1, 4'd6, 0, 0, "fetch_jne", F_GO);  cyc(1, 4'd6, 0, 0, "jne_z0", JMP_T);
    cyc(1, 4'd4, 1, 1, "fetch_jmp", F_GO);
    cyc(0, 4'd4, 1, 1, "exec_jmp", JMP_T);
    cyc(1, 4'd9, 0, 0, "fetch_nop", F_GO);  cyc(0, 4'd9, 0, 0, "exec_nop", ZERO);
    for (int i = 0; i < 3; i++) cyc(0, 4'd0, 0, 0, "fetch_wait", F_WAIT);
    cyc(1, 4'd0, 0, 0, "fetch_done", F_GO);
    cyc(0, 4'd0, 0, 0, "lda_wait", LDA_W);  cyc(1, 4'd0, 0, 0, "lda_done", LDA_X);
    cyc(1, 4'd7, 0, 0, "fetch_stp", F_GO);  cyc(0, 4'd7, 0, 0, "exec_stp", ZERO);
    for (int i = 0; i < 3; i++) cyc(i[0], 4'd0, 0, 0, "halted", HLT);
    Reset = 1'b0;
    cyc(1, 4'd0, 0, 0, "halt_reset", ZERO);
    Reset = 1'b1;
    cyc(1, 4'd9, 0, 0, "fetch_nop2", F_GO); cyc(1, 4'd9, 0, 0, "exec_nop2", ZERO);
    for (int i = 0; i < 15; i++) cyc(0, 4'd0, 0, 0, "timeout_wait", F_WAIT);
    for (int i = 0; i < 3; i++) cyc(i[0], 4'd0, 0, 0, "fault", FLT);
    chk("fault_held", FLT);
    Reset = 1'b0;
    #1;
    chk("fault_reset_async", ZERO);
    @(posedge Clk); #1;
    Reset = 1'b1;
    cyc(1, 4'd1, 0, 0, "fetch_sta2", F_GO);
    Mem_Ready = 1'b0; Opcode = 4'd1;
    exp_q.push_back('{"sta_wait", STA_X});
    @(negedge Clk); #1;
    Reset = 1'b0;
    #1;
    chk("sta_async_reset", ZERO);
    @(posedge Clk); #1;
    Reset = 1'b1;
    cyc(1, 4'd0, 0, 0, "fetch_after_reset", F_GO);
    @(negedge Clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
